// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate defaults, receiver FSM states and the
// clock divider calculation used by both the receiver and uart_tx.
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_FREQ = 27_000_000;
    localparam int unsigned DEFAULT_BAUD     = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned calc_div(
        input int unsigned clk_freq,
        input int unsigned baud,
        input int unsigned oversample
    );
        int unsigned denom;
        denom = baud * oversample;
        return (clk_freq + denom / 2) / denom;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// data_o whenever valid_o is high; occupancy is tracked by a separate counter.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop     = pop_i & ~empty;
    assign do_push    = push_i & (~full | do_pop);
    assign overflow_o = push_i & full & ~do_pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Empty output reads as zero so stale storage never leaks after a flush.
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o = ~empty;
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Debug UART receiver: synchronizes the rx pin, recovers 8N1 frames with a
// 3-sample majority vote per bit and queues good bytes in a FWFT FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD       = DEFAULT_BAUD,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_rx,
    output logic [7:0]                  O_data,
    output logic                        O_valid,
    input  logic                        I_ready,
    output logic                        O_frame_err,
    output logic                        O_overrun,
    output logic [$clog2(FIFO_DEPTH):0] O_fifo_count,
    output logic                        O_busy
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned T_W   = $clog2(OVERSAMPLE);

    rx_state_e        state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [T_W-1:0]   t_q, t_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       samp_q, samp_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q;
    logic             tick, fall, vote, push, fifo_overflow;
    logic             samp_lo, samp_mid, decide, bit_end;

    assign tick     = (div_cnt_q == DIV_W'(DIV - 1));
    assign fall     = prev_q & ~sync2_q;
    assign samp_lo  = tick && (t_q == T_W'(OVERSAMPLE / 2 - 1));
    assign samp_mid = tick && (t_q == T_W'(OVERSAMPLE / 2));
    assign decide   = tick && (t_q == T_W'(OVERSAMPLE / 2 + 1));
    assign bit_end  = tick && (t_q == T_W'(OVERSAMPLE - 1));

    // Third sample is taken live from the synchronizer on the decision tick.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
        t_d         = t_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        samp_d      = samp_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        if (tick) begin
            t_d = bit_end ? '0 : t_q + T_W'(1);
        end
        if (samp_lo) begin
            samp_d[0] = sync2_q;
        end
        if (samp_mid) begin
            samp_d[1] = sync2_q;
        end

        case (state_q)
            ST_IDLE: begin
                // Counters parked at zero so bit timing starts at the edge.
                div_cnt_d = '0;
                t_d       = '0;
                if (fall) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (decide && vote) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d = {vote, shift_q[7:1]};
                end
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                // Leave at mid-stop so a zero-gap next start edge is seen.
                if (decide) begin
                    if (vote) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (sync2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            t_q         <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            samp_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= uart_rx;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            t_q         <= t_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            samp_q      <= samp_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= fifo_overflow;
        end
    end

    // Output handshake: a byte transfers on every clock where O_valid and
    // I_ready are both high; O_data holds steady while O_valid waits for I_ready.
    sync_fifo_fwft #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_i       (I_ready),
        .data_o      (O_data),
        .valid_o     (O_valid),
        .count_o     (O_fifo_count),
        .overflow_o  (fifo_overflow)
    );

    assign O_frame_err = frame_err_q;
    assign O_overrun   = overrun_q;
    assign O_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives serial frames on the rx pin and checks the
// delivered byte stream against a queue model of what a receiver must deliver.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    // 12 MHz / (115200 * 16) = 6.51 -> 7 clocks per tick, 112 clocks per bit.
    localparam int CLK_HZ = 12_000_000;
    localparam int BIT    = 112;
    localparam int DEPTH  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       I_ready = 1'b0;
    logic [7:0] O_data;
    logic       O_valid, O_frame_err, O_overrun, O_busy;
    logic [4:0] O_fifo_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    int exp_overruns = 0;
    int valid_cycles = 0;
    int fe_pulses    = 0;
    int ov_pulses    = 0;
    int max_count    = 0;
    bit busy_seen    = 1'b0;

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_HZ),
        .BAUD       (115200),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .O_data       (O_data),
        .O_valid      (O_valid),
        .I_ready      (I_ready),
        .O_frame_err  (O_frame_err),
        .O_overrun    (O_overrun),
        .O_fifo_count (O_fifo_count),
        .O_busy       (O_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // A good frame adds its byte unless the receiver already holds DEPTH bytes.
    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_overruns++;
    endtask

    // Called on a falling clock edge; leaves the line at the stop level.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_clks);
        uart_rx = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (bit_clks) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (bit_clks / 4) @(negedge clk);
        if (stop_bit) model_push(b);
        repeat (bit_clks - bit_clks / 4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, O_valid, 0);
        check({tag, "_data"}, O_data, 0);
        check({tag, "_frame_err"}, O_frame_err, 0);
        check({tag, "_overrun"}, O_overrun, 0);
        check({tag, "_count"}, O_fifo_count, 0);
        check({tag, "_busy"}, O_busy, 0);
    endtask

    // Output monitor: the head byte must match the model whenever it is offered.
    always @(negedge clk) begin
        #1;
        if (rst === 1'b0) begin
            if (O_valid === 1'b1) begin
                valid_cycles++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_byte: observed=0x%0h expected=no byte", O_data);
                end
                if (exp_q.size() != 0) begin
                    checks++;
                    assert (O_data === exp_q[0]) else begin
                        errors++;
                        $error("FAIL head_data: observed=0x%0h expected=0x%0h", O_data, exp_q[0]);
                    end
                    if (I_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
            if (O_frame_err === 1'b1) fe_pulses++;
            if (O_overrun === 1'b1) ov_pulses++;
            if (O_busy === 1'b1) busy_seen = 1'b1;
            if (int'(O_fifo_count) > max_count) max_count = int'(O_fifo_count);
        end
    end

    initial begin
        int v0;
        logic [7:0] rb;
        int bc;
        int gap;

        // Reset
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);

        // Single byte, consumer always ready
        I_ready   = 1'b1;
        max_count = 0;
        v0        = valid_cycles;
        send_byte(8'h55, 1'b1, BIT);
        repeat (20) @(negedge clk);
        check("x55_valid_cycles", valid_cycles - v0, 1);
        check("x55_count_peak", max_count, 1);
        check("x55_delivered", exp_q.size(), 0);
        check("x55_frame_err", fe_pulses, 0);
        check("x55_overrun", ov_pulses, 0);

        // Short glitch must be rejected as a false start
        v0        = valid_cycles;
        busy_seen = 1'b0;
        uart_rx   = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (BIT) @(negedge clk);
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_end", O_busy, 0);
        check("glitch_no_valid", valid_cycles - v0, 0);
        check("glitch_frame_err", fe_pulses, 0);

        // Framing error followed by a long break, then a good byte
        send_byte(8'hA5, 1'b0, BIT);
        repeat (2000) @(negedge clk);
        check("break_busy", O_busy, 1);
        uart_rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("ferr_pulses", fe_pulses, 1);
        check("ferr_idle", O_busy, 0);
        send_byte(8'h3C, 1'b1, BIT);
        repeat (20) @(negedge clk);
        check("ferr_next_delivered", exp_q.size(), 0);
        check("ferr_overrun", ov_pulses, 0);

        // Fill past capacity with the consumer stalled
        I_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 1'b1, BIT);
            if (i == 15) begin
                repeat (4) @(negedge clk);
                check("fill16_count", O_fifo_count, exp_q.size());
                check("fill16_overrun", ov_pulses, exp_overruns);
            end
        end
        repeat (4) @(negedge clk);
        check("fill17_count", O_fifo_count, exp_q.size());
        check("fill17_overrun", ov_pulses, exp_overruns);
        check("fill17_valid", O_valid, 1);
        I_ready = 1'b1;
        repeat (24) @(negedge clk);
        check("drain_all", exp_q.size(), 0);
        check("drain_count", O_fifo_count, 0);
        check("drain_valid", O_valid, 0);

        // Back-to-back frames at nominal, fast and slow sender rates
        v0 = valid_cycles;
        for (int s = 0; s < 3; s++) begin
            bc = (s == 0) ? BIT : ((s == 1) ? BIT - 2 : BIT + 2);
            send_byte(8'h00, 1'b1, bc);
            send_byte(8'hFF, 1'b1, bc);
            uart_rx = 1'b1;
            repeat (20) @(negedge clk);
            check("b2b_delivered", exp_q.size(), 0);
        end
        check("b2b_valid_cycles", valid_cycles - v0, 6);
        check("b2b_frame_err", fe_pulses, 1);

        // Randomized bytes, rates, gaps and consumer stalls
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0:       bc = BIT - 2;
                1:       bc = BIT;
                default: bc = BIT + 2;
            endcase
            I_ready = 1'($urandom_range(0, 1));
            send_byte(rb, 1'b1, bc);
            gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 200));
            repeat (gap) @(negedge clk);
        end
        I_ready = 1'b1;
        repeat (24) @(negedge clk);
        check("rand_delivered", exp_q.size(), 0);
        check("rand_count", O_fifo_count, 0);

        // Reset in the middle of a data bit with three bytes queued
        I_ready = 1'b0;
        send_byte(8'h11, 1'b1, BIT);
        send_byte(8'h22, 1'b1, BIT);
        send_byte(8'h33, 1'b1, BIT);
        repeat (4) @(negedge clk);
        check("preflush_count", O_fifo_count, 3);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rb = 8'h99;
        for (int i = 0; i < 3; i++) begin
            uart_rx = rb[i];
            repeat (BIT) @(negedge clk);
        end
        check("midframe_busy", O_busy, 1);
        rst     = 1'b1;
        uart_rx = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        check_reset_outputs("midreset");
        rst     = 1'b0;
        I_ready = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        send_byte(8'h7E, 1'b1, BIT);
        repeat (20) @(negedge clk);
        check("post_reset_delivered", exp_q.size(), 0);
        check("post_reset_count", O_fifo_count, 0);

        check("total_overruns", ov_pulses, exp_overruns);
        check("total_frame_errs", fe_pulses, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
